// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : MIPS IF stage: PC, imem addressing, IF/ID register, fetch stats.
// Revision: 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter int          IMEM_AW   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               id_valid,
  output logic [31:0]        fetch_count,
  output logic               fetch_err
);

  // Window bounds carried in 33 bits so the upper bound cannot wrap.
  localparam logic [32:0] c_win_lo = {1'b0, TEXT_BASE};
  localparam logic [32:0] c_win_hi = c_win_lo + (33'd4 << IMEM_AW);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        r_id_valid;
  logic [31:0] r_fetch_count;
  logic        r_fetch_err;

  logic [31:0] w_pc4;
  logic        w_in_window;

  assign w_pc4       = r_pc + 32'd4;
  assign w_in_window = ({1'b0, r_pc} >= c_win_lo) && ({1'b0, r_pc} < c_win_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= TEXT_BASE;
      r_id_instr    <= '0;
      r_id_pc       <= '0;
      r_id_pc4      <= '0;
      r_id_valid    <= 1'b0;
      r_fetch_count <= '0;
      r_fetch_err   <= 1'b0;
    end else if (redirect_valid) begin
      // Squash the sequential fetch; id_pc/id_pc4 keep their old values.
      r_pc       <= {redirect_target[31:2], 2'b00};
      r_id_instr <= '0;
      r_id_valid <= 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        r_fetch_err <= 1'b1;
      end
    end else if (!stall) begin
      r_id_instr    <= imem_dout;
      r_id_pc       <= r_pc;
      r_id_pc4      <= w_pc4;
      r_id_valid    <= 1'b1;
      r_pc          <= w_pc4;
      r_fetch_count <= r_fetch_count + 32'd1;
      if (!w_in_window) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign imem_addr   = r_pc[IMEM_AW+1:2];
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc4      = r_id_pc4;
  assign id_valid    = r_id_valid;
  assign fetch_count = r_fetch_count;
  assign fetch_err   = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed table, corner sequences and random run vs. a PC model.
// Revision: 1.0
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] TB_BASE = 32'h0040_0000;
  localparam int          AW      = 9;
  localparam int          WORDS   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic [31:0]   id_pc4;
  logic          id_valid;
  logic [31:0]   fetch_count;
  logic          fetch_err;

  logic [31:0] mem [0:WORDS-1];

  always #5 clk = ~clk;
  assign imem_dout = mem[imem_addr];

  fetch_stage #(.TEXT_BASE(TB_BASE), .IMEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_dout(imem_dout),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid),
    .fetch_count(fetch_count), .fetch_err(fetch_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: architectural PC and IF/ID contents.
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_cnt;
  logic        m_valid, m_err;

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return mem[(byte_addr / 4) % WORDS];
  endfunction

  task automatic model_reset();
    m_pc = TB_BASE; m_instr = 0; m_idpc = 0; m_idpc4 = 0;
    m_cnt = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic st, input logic rv, input logic [31:0] tgt);
    if (rv) begin
      if (tgt % 4 != 0) m_err = 1;
      m_pc = tgt - (tgt % 4);
      m_instr = 0;
      m_valid = 0;
    end else if (!st) begin
      if (m_pc < TB_BASE || m_pc >= TB_BASE + 4 * WORDS) m_err = 1;
      m_instr = word_at(m_pc);
      m_idpc  = m_pc;
      m_idpc4 = m_pc + 4;
      m_valid = 1;
      m_pc    = m_pc + 4;
      m_cnt   = m_cnt + 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_addr"},  32'(imem_addr), (m_pc / 4) % WORDS);
    chk({tag, "_instr"}, id_instr, m_instr);
    chk({tag, "_pc"},    id_pc, m_idpc);
    chk({tag, "_pc4"},   id_pc4, m_idpc4);
    chk({tag, "_valid"}, 32'(id_valid), 32'(m_valid));
    chk({tag, "_cnt"},   fetch_count, m_cnt);
    chk({tag, "_err"},   32'(fetch_err), 32'(m_err));
  endtask

  task automatic step(input logic st, input logic rv, input logic [31:0] tgt, input string tag);
    stall = st; redirect_valid = rv; redirect_target = tgt;
    model_edge(st, rv, tgt);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Asynchronous pulse placed well between edges; checked before the next edge.
  task automatic async_reset(input string tag);
    stall = 0; redirect_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(id_valid), 0);
    chk({tag, "_cnt"}, fetch_count, 0);
    chk({tag, "_err"}, 32'(fetch_err), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_instr"}, id_instr, 0);
    chk({tag, "_pc"}, id_pc, 0);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h2408_0000 ^ (i * 32'h0001_0107);

    tbl[0]  = '{0, 0, 0,            32'h0040_0000, 1, 1,   1, 0};
    tbl[1]  = '{0, 0, 0,            32'h0040_0004, 1, 2,   2, 0};
    tbl[2]  = '{0, 0, 0,            32'h0040_0008, 1, 3,   3, 0};
    tbl[3]  = '{0, 0, 0,            32'h0040_000C, 1, 4,   4, 0};
    tbl[4]  = '{1, 0, 0,            32'h0040_000C, 1, 4,   4, 0};
    tbl[5]  = '{1, 0, 0,            32'h0040_000C, 1, 4,   4, 0};
    tbl[6]  = '{1, 0, 0,            32'h0040_000C, 1, 4,   4, 0};
    tbl[7]  = '{0, 0, 0,            32'h0040_0010, 1, 5,   5, 0};
    tbl[8]  = '{0, 1, 32'h0040_01C8, 32'h0040_0010, 0, 114, 5, 0};
    tbl[9]  = '{0, 0, 0,            32'h0040_01C8, 1, 115, 6, 0};
    tbl[10] = '{1, 1, 32'h0040_0054, 32'h0040_01C8, 0, 21,  6, 0};
    tbl[11] = '{0, 0, 0,            32'h0040_0054, 1, 22,  7, 0};
    tbl[12] = '{0, 1, 32'h0040_0102, 32'h0040_0054, 0, 64,  7, 1};
    tbl[13] = '{0, 0, 0,            32'h0040_0100, 1, 65,  8, 1};
    tbl[14] = '{0, 0, 0,            32'h0040_0104, 1, 66,  9, 1};

    rst_n = 1'b0; stall = 0; redirect_valid = 0; redirect_target = 0;
    #12;
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_pc4", id_pc4, 0);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_err", 32'(fetch_err), 0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].st, tbl[i].rv, tbl[i].tgt, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_exp_pc", i), id_pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_exp_pc4", i), id_pc4, tbl[i].exp_pc + 32'd4);
      chk($sformatf("tbl%0d_exp_valid", i), 32'(id_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_exp_instr", i), id_instr,
          tbl[i].exp_valid ? mem[(tbl[i].exp_pc - TB_BASE) / 4] : 32'h0);
      chk($sformatf("tbl%0d_exp_addr", i), 32'(imem_addr), tbl[i].exp_addr);
      chk($sformatf("tbl%0d_exp_cnt", i), fetch_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_exp_err", i), 32'(fetch_err), 32'(tbl[i].exp_err));
    end

    async_reset("arst1");
    // Top edge of the window: last word is legal, the next one aliases and flags.
    step(0, 1, 32'h0040_07FC, "hi_redir");
    step(0, 0, 0, "hi_last");
    chk("hi_last_err", 32'(fetch_err), 0);
    step(0, 0, 0, "hi_past");
    chk("hi_past_err", 32'(fetch_err), 1);
    chk("hi_past_instr", id_instr, mem[0]);
    step(1, 0, 0, "hi_hold");
    chk("hi_hold_err", 32'(fetch_err), 1);

    async_reset("arst2");
    step(0, 1, 32'h003F_FFFC, "lo_redir");
    chk("lo_redir_err", 32'(fetch_err), 0);
    step(1, 0, 0, "lo_stall");
    chk("lo_stall_err", 32'(fetch_err), 0);
    step(0, 0, 0, "lo_fetch");
    chk("lo_fetch_err", 32'(fetch_err), 1);
    step(0, 0, 0, "lo_next");

    async_reset("arst3");
    for (int n = 0; n < 400; n++) begin
      logic        st, rv;
      logic [31:0] tgt;
      int          r;
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 6) == 0);
      r  = $urandom_range(0, 9);
      if (r < 7)       tgt = TB_BASE + 4 * $urandom_range(0, WORDS - 1);
      else if (r == 7) tgt = TB_BASE + $urandom_range(0, 4 * WORDS - 1);
      else if (r == 8) tgt = TB_BASE + 4 * WORDS + 4 * $urandom_range(0, 15);
      else             tgt = TB_BASE - 4 * $urandom_range(1, 8);
      step(st, rv, tgt, $sformatf("rnd%0d", n));
      if (n == 200) async_reset("arst4");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. Downstream, the decode stage sees the instruction, its PC, and its PC+4. Redirects from the branch/jump unit and stalls from the hazard unit are applied here, and the stage keeps a fetch counter plus a sticky fetch-error flag.

## Interface

- `TEXT_BASE`, 32'h0040_0000, PC reset value and base of the instruction window.
- `IMEM_AW`, 9, instruction-memory word-address width; the window is 2^IMEM_AW words.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `stall` input 1: hazard-unit hold; freezes the PC and IF/ID.
- `redirect_valid` input 1: a taken branch, j, jal or jr resolved downstream.
- `redirect_target` input 32: byte address of the next instruction when `redirect_valid`=1.
- `imem_addr` output IMEM_AW: word address to the instruction memory, equal to `pc[IMEM_AW+1:2]`.
- `imem_dout` input 32: instruction word returned combinationally by the instruction memory.
- `id_instr` output 32: IF/ID instruction.
- `id_pc` output 32: IF/ID instruction address.
- `id_pc4` output 32: IF/ID `id_pc`+4, used as the link value for jal.
- `id_valid` output 1: IF/ID holds a real instruction; 0 means bubble.
- `fetch_count` output 32: number of instructions latched into IF/ID.
- `fetch_err` output 1: sticky flag for a misaligned or out-of-window fetch.

## Operation

- **State.** The stage holds `pc` (32 bits), the IF/ID register (`id_instr`, `id_pc`, `id_pc4`, `id_valid`), `fetch_count`, and `fetch_err`.
- **Reset values.** `pc`=TEXT_BASE, `id_instr`=0 (nop), `id_pc`=0, `id_pc4`=0, `id_valid`=0, `fetch_count`=0, `fetch_err`=0. `imem_addr` is then 0.
- **Per-edge priority**, highest first:
  1. `redirect_valid`=1:
     - `pc` ← {`redirect_target[31:2]`, 2'b00}.
     - IF/ID ← bubble (`id_instr`=0, `id_valid`=0; `id_pc` and `id_pc4` hold).
     - `fetch_count` does not change.
     - Redirect overrides `stall`.
  2. `stall`=1: `pc`, IF/ID and `fetch_count` all hold.
  3. Otherwise:
     - `id_instr` ← `imem_dout`, `id_pc` ← `pc`, `id_pc4` ← `pc`+4, `id_valid` ← 1.
     - `pc` ← `pc`+4.
     - `fetch_count` ← `fetch_count`+1.
- **Arithmetic.** PC+4 is modulo 2^32. `fetch_count` wraps from 32'hFFFF_FFFF to 0.
- **Address.** `imem_addr` is purely combinational from `pc`. Only bits [IMEM_AW+1:2] are used, so a PC past the window aliases to its start.
- **Errors.** `fetch_err` is set, and stays set until reset, when either:
  - a redirect is accepted with `redirect_target[1:0]`≠0; or
  - an unstalled fetch occurs with `pc` outside [TEXT_BASE, TEXT_BASE+4·2^IMEM_AW).

  Neither condition changes any other behaviour.
- **jr/jal.** The target is computed downstream; this stage only loads it. A jal link value is taken from `id_pc4` of the jal instruction.
- **Delay slots.** There is no delay slot. The sequential instruction fetched behind a taken control transfer is squashed by the redirect bubble.

## Timing

- **Memory path.** `imem_addr` changes combinationally after the `pc` register update. `imem_dout` must settle within the same cycle.
- **Fetch latency.** An instruction appears on the IF/ID outputs one edge after its `pc` is presented.
- **Redirect penalty.** One bubble cycle. The target instruction is in IF/ID on the second edge after `redirect_valid` is sampled.
- **Stall.** A stall of N cycles holds all outputs constant for N edges. The first unstalled edge continues from the held `pc`.
- **Reset.** Assertion of `rst_n` mid-cycle clears state immediately, with no clock needed. After deassertion, the first edge latches the TEXT_BASE instruction (`id_pc`=0x0040_0000, `id_valid`=1).
- **Inputs.** `stall` and `redirect_valid` are sampled only on rising edges; they have no combinational path to outputs.

## Test plan

- **Reset.** Hold `rst_n`=0 and check that every output is at its reset value and `imem_addr`=0. Release, then over 3 edges check `id_pc` = 0x0040_0000, 0x0040_0004, 0x0040_0008, with `id_instr` equal to memory words 0, 1, 2 and `fetch_count`=3.
- **Stall.** After 4 fetches, assert `stall` for 3 cycles. `id_pc` stays at 0x0040_000C, `imem_addr` stays at 4, and `fetch_count` stays at 4. Release, and the next edge gives `id_pc`=0x0040_0010.
- **Redirect (jal).** Assert `redirect_valid` with target 0x0040_01C8. The next edge gives `id_valid`=0, `id_instr`=0 and `imem_addr`=114. The edge after gives `id_pc`=0x0040_01C8 and `id_pc4`=0x0040_01CC.
- **Redirect and stall together.** Assert both in the same cycle with target 0x0040_0054. The redirect wins: a bubble is inserted and `pc`=0x0040_0054.
- **Misaligned redirect.** Redirect to target 0x0040_0102. `pc` becomes 0x0040_0100, `fetch_err` becomes 1, and it stays 1 through subsequent normal fetches until reset.
- **Asynchronous reset mid-run.** Pulse `rst_n` low between clock edges while `id_valid`=1. Outputs clear within that same cycle without waiting for an edge.
